// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler sharing one spi_master among several clients; each grant is
// serialised as a CMD/[ADDR]/DATA frame over the master's dv/dr byte handshake.
module spi_xfer_sched #(
    parameter int NR_REQUESTERS  = 4,
    parameter int SPI_DATA_WIDTH = 8,
    parameter bit SHORT_ADDR_EN  = 1'b0,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NR_REQUESTERS-1:0]                       req,
    input  logic [NR_REQUESTERS-1:0]                       req_write,
    input  logic [NR_REQUESTERS*(2*SPI_DATA_WIDTH-2)-1:0]  req_addr,
    input  logic [NR_REQUESTERS*SPI_DATA_WIDTH-1:0]        req_wdata,
    output logic [NR_REQUESTERS-1:0]                       gnt,
    output logic [NR_REQUESTERS-1:0]                       done,
    output logic [SPI_DATA_WIDTH-1:0]                      rdata,
    output logic [SPI_DATA_WIDTH-1:0]                      status,
    output logic [SPI_DATA_WIDTH-1:0]                      m_spi_d,
    output logic                                           m_spi_dv,
    input  logic                                           m_spi_dr,
    input  logic [SPI_DATA_WIDTH-1:0]                      s_spi_d,
    input  logic                                           s_spi_dv,
    input  logic                                           spi_cs_n
);
    localparam int DW = SPI_DATA_WIDTH;
    localparam int AW = 2 * SPI_DATA_WIDTH - 2;
    localparam int IW = $clog2(NR_REQUESTERS);

    typedef enum logic [2:0] {WAIT_CS, GAP, IDLE, CMD, ADDR, DATA, DONE} state_t;
    typedef enum logic [1:0] {SEND, ACK, RX} phase_t;

    state_t                   r_state, w_state_next;
    phase_t                   r_phase, w_phase_next;
    logic [7:0]               r_gap_cnt, w_gap_next;
    logic [IW-1:0]            r_last, w_last_next;
    logic [IW-1:0]            r_idx, w_idx_next;
    logic                     r_write, w_write_next;
    logic [AW-1:0]            r_addr, w_addr_next;
    logic [DW-1:0]            r_wdata, w_wdata_next;
    logic [NR_REQUESTERS-1:0] r_gnt, w_gnt_next;
    logic [NR_REQUESTERS-1:0] r_done, w_done_next;
    logic [DW-1:0]            r_rdata, w_rdata_next;
    logic [DW-1:0]            r_status, w_status_next;
    logic [DW-1:0]            r_m_d, w_m_d_next;
    logic                     r_m_dv, w_m_dv_next;

    logic [AW-1:0]            w_addr_arr  [NR_REQUESTERS];
    logic [DW-1:0]            w_wdata_arr [NR_REQUESTERS];
    logic                     w_pick_found;
    logic [IW-1:0]            w_pick_idx;
    int                       w_cand;
    logic                     w_short;
    logic [DW-1:0]            w_tx_byte;

    genvar gi;
    generate
        for (gi = 0; gi < NR_REQUESTERS; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign w_wdata_arr[gi] = req_wdata[gi*DW +: DW];
        end
    endgenerate

    // Walk from farthest to nearest so the client closest after r_last wins.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_cand       = 0;
        for (int k = NR_REQUESTERS; k >= 1; k--) begin
            w_cand = int'(r_last) + k;
            if (w_cand >= NR_REQUESTERS) w_cand = w_cand - NR_REQUESTERS;
            if (req[w_cand[IW-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand[IW-1:0];
            end
        end
    end

    assign w_short = SHORT_ADDR_EN && (r_addr[AW-1:DW-2] == '0);

    always_comb begin
        w_tx_byte = '0;
        case (r_state)
            CMD:     w_tx_byte = w_short ? {r_write, 1'b0, r_addr[DW-3:0]}
                                         : {r_write, 1'b1, r_addr[AW-1:DW]};
            ADDR:    w_tx_byte = r_addr[DW-1:0];
            DATA:    w_tx_byte = r_write ? r_wdata : '0;
            default: w_tx_byte = '0;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_phase_next  = r_phase;
        w_gap_next    = r_gap_cnt;
        w_last_next   = r_last;
        w_idx_next    = r_idx;
        w_write_next  = r_write;
        w_addr_next   = r_addr;
        w_wdata_next  = r_wdata;
        w_gnt_next    = r_gnt;
        w_done_next   = '0;
        w_rdata_next  = r_rdata;
        w_status_next = r_status;
        w_m_d_next    = r_m_d;
        w_m_dv_next   = r_m_dv;
        case (r_state)
            WAIT_CS: begin
                if (spi_cs_n) begin
                    w_state_next = GAP;
                    w_gap_next   = '0;
                end
            end
            GAP: begin
                if (r_gap_cnt == 8'(GAP_CYCLES - 1)) begin
                    w_state_next = IDLE;
                    w_gap_next   = '0;
                end else begin
                    w_gap_next = r_gap_cnt + 8'd1;
                end
            end
            IDLE: begin
                if (w_pick_found) begin
                    w_gnt_next             = '0;
                    w_gnt_next[w_pick_idx] = 1'b1;
                    w_idx_next             = w_pick_idx;
                    w_write_next           = req_write[w_pick_idx];
                    w_addr_next            = w_addr_arr[w_pick_idx];
                    w_wdata_next           = w_wdata_arr[w_pick_idx];
                    w_state_next           = CMD;
                    w_phase_next           = SEND;
                end
            end
            CMD, ADDR, DATA: begin
                case (r_phase)
                    SEND: begin
                        if (m_spi_dr) begin
                            w_m_d_next   = w_tx_byte;
                            w_m_dv_next  = 1'b1;
                            w_phase_next = ACK;
                        end
                    end
                    ACK: begin
                        if (!m_spi_dr) begin
                            w_m_dv_next  = 1'b0;
                            w_phase_next = RX;
                        end
                    end
                    default: begin
                        if (s_spi_dv) begin
                            w_phase_next = SEND;
                            if (r_state == CMD) begin
                                w_status_next = s_spi_d;
                                w_state_next  = w_short ? DATA : ADDR;
                            end else if (r_state == ADDR) begin
                                w_state_next = DATA;
                            end else begin
                                w_rdata_next = s_spi_d;
                                w_done_next  = r_gnt;
                                w_gnt_next   = '0;
                                w_state_next = DONE;
                            end
                        end
                    end
                endcase
            end
            DONE: begin
                w_last_next  = r_idx;
                w_state_next = WAIT_CS;
            end
            default: w_state_next = WAIT_CS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= WAIT_CS;
            r_phase   <= SEND;
            r_gap_cnt <= '0;
            r_last    <= IW'(NR_REQUESTERS - 1);
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_status  <= '0;
            r_m_d     <= '0;
            r_m_dv    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_phase   <= w_phase_next;
            r_gap_cnt <= w_gap_next;
            r_last    <= w_last_next;
            r_idx     <= w_idx_next;
            r_write   <= w_write_next;
            r_addr    <= w_addr_next;
            r_wdata   <= w_wdata_next;
            r_gnt     <= w_gnt_next;
            r_done    <= w_done_next;
            r_rdata   <= w_rdata_next;
            r_status  <= w_status_next;
            r_m_d     <= w_m_d_next;
            r_m_dv    <= w_m_dv_next;
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign status   = r_status;
    assign m_spi_d  = r_m_d;
    assign m_spi_dv = r_m_dv;
endmodule

// File: tb/tb_spi_xfer_sched.sv
// Two schedulers (long-only and short-frame enabled), each driven by a behavioural
// spi_master model, checked against a frame/arbitration reference model.
module tb_spi_xfer_sched;
    localparam int N        = 4;
    localparam int DW       = 8;
    localparam int AW       = 14;
    localparam int GAP      = 4;
    localparam int BYTE_CYC = 4;
    localparam int CS_HOLD  = 6;
    localparam int BUDGET   = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0][N-1:0]    req, req_write, gnt, done;
    logic [1:0][N*AW-1:0] req_addr;
    logic [1:0][N*DW-1:0] req_wdata;
    logic [1:0][DW-1:0]   rdata, status, m_d, s_d;
    logic [1:0]           m_dv, m_dr, s_dv, cs_n;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            spi_xfer_sched #(
                .NR_REQUESTERS (N),
                .SPI_DATA_WIDTH(DW),
                .SHORT_ADDR_EN (gi == 1 ? 1'b1 : 1'b0),
                .GAP_CYCLES    (GAP)
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .req      (req[gi]),
                .req_write(req_write[gi]),
                .req_addr (req_addr[gi]),
                .req_wdata(req_wdata[gi]),
                .gnt      (gnt[gi]),
                .done     (done[gi]),
                .rdata    (rdata[gi]),
                .status   (status[gi]),
                .m_spi_d  (m_d[gi]),
                .m_spi_dv (m_dv[gi]),
                .m_spi_dr (m_dr[gi]),
                .s_spi_d  (s_d[gi]),
                .s_spi_dv (s_dv[gi]),
                .spi_cs_n (cs_n[gi])
            );
        end
    endgenerate

    // spi_master model: accepts a byte, shifts for BYTE_CYC cycles, returns a byte,
    // and raises chip select after CS_HOLD idle cycles.
    logic [7:0] tx_buf    [2][1024];
    logic [7:0] rx_buf    [2][1024];
    logic [7:0] plan_resp [2][1024];
    bit         plan_ok   [2][1024];
    int tx_n [2];
    int busy [2];
    int idle [2];
    int cs_rise_cyc [2];

    initial begin
        int slot;
        m_dr = '1;
        cs_n = '1;
        s_dv = '0;
        s_d  = '0;
        for (int u = 0; u < 2; u++) begin
            tx_n[u] = 0; busy[u] = 0; idle[u] = 0; cs_rise_cyc[u] = 0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                s_dv[u] = 1'b0;
                if (busy[u] > 0) begin
                    busy[u] = busy[u] - 1;
                    if (busy[u] == 0) begin
                        slot = (tx_n[u] - 1) & 1023;
                        s_d[u] = plan_ok[u][slot] ? plan_resp[u][slot] : 8'($urandom);
                        rx_buf[u][slot] = s_d[u];
                        s_dv[u] = 1'b1;
                        m_dr[u] = 1'b1;
                        idle[u] = 0;
                    end
                end else if (m_dv[u] && m_dr[u]) begin
                    tx_buf[u][tx_n[u] & 1023] = m_d[u];
                    tx_n[u] = tx_n[u] + 1;
                    m_dr[u] = 1'b0;
                    cs_n[u] = 1'b0;
                    busy[u] = BYTE_CYC;
                end else if (!cs_n[u]) begin
                    idle[u] = idle[u] + 1;
                    if (idle[u] >= CS_HOLD) begin
                        cs_n[u] = 1'b1;
                        cs_rise_cyc[u] = cyc;
                    end
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference model
    bit            cw [N];
    logic [AW-1:0] ca [N];
    logic [DW-1:0] cd [N];
    int last_m [2];
    bit gap_chk [2];
    int done_cyc [2];

    function automatic int pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++)
            if (mask[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic void frame(input int u, input bit w, input int a, input int d,
                                  output int len, output logic [2:0][7:0] b);
        b = '0;
        if (u == 1 && a < 64) begin
            len  = 2;
            b[0] = 8'((w ? 128 : 0) + a);
            b[1] = w ? 8'(d) : 8'h00;
        end else begin
            len  = 3;
            b[0] = 8'((w ? 128 : 0) + 64 + (a >> 8));
            b[1] = 8'(a % 256);
            b[2] = w ? 8'(d) : 8'h00;
        end
    endfunction

    task automatic drive(input int u);
        for (int i = 0; i < N; i++) begin
            req_write[u][i]          = cw[i];
            req_addr[u][i*AW +: AW]  = ca[i];
            req_wdata[u][i*DW +: DW] = cd[i];
        end
    endtask

    task automatic randomize_clients();
        for (int i = 0; i < N; i++) begin
            cw[i] = 1'($urandom);
            ca[i] = ($urandom_range(0, 1) == 1) ? 14'($urandom) : 14'($urandom_range(0, 63));
            cd[i] = 8'($urandom);
        end
    endtask

    task automatic plan(input int u, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        plan_resp[u][tx_n[u] & 1023]       = b0; plan_ok[u][tx_n[u] & 1023]       = 1'b1;
        plan_resp[u][(tx_n[u] + 1) & 1023] = b1; plan_ok[u][(tx_n[u] + 1) & 1023] = 1'b1;
        plan_resp[u][(tx_n[u] + 2) & 1023] = b2; plan_ok[u][(tx_n[u] + 2) & 1023] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            last_m[u]  = N - 1;
            gap_chk[u] = 1'b0;
        end
    endtask

    task automatic do_xfer(input int u, input logic [N-1:0] mask, input bit keep, input bit scramble);
        int w, len, base, n, gnt_cyc;
        logic [2:0][7:0] b;
        bit hold_ok;
        w = pick(mask, last_m[u]);
        frame(u, cw[w], int'(ca[w]), int'(cd[w]), len, b);
        drive(u);
        req[u] = mask;
        n = 0;
        while (gnt[u] == '0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_eq("gnt_wait", 32'(n < BUDGET), 1);
        if (n >= BUDGET) return;
        gnt_cyc = cyc;
        base    = tx_n[u];
        check_eq($sformatf("u%0d gnt", u), 32'(gnt[u]), 1 << w);
        if (gap_chk[u])
            check_eq("gap", 32'((cs_rise_cyc[u] > done_cyc[u]) && (gnt_cyc - cs_rise_cyc[u] >= GAP + 1)), 1);
        if (!keep) req[u] = '0;
        if (scramble) begin
            randomize_clients();
            drive(u);
        end
        hold_ok = 1'b1;
        n = 0;
        while (done[u] == '0 && n < BUDGET) begin
            if (gnt[u] != N'(1 << w)) hold_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check_eq("done_wait", 32'(n < BUDGET), 1);
        check_eq($sformatf("u%0d done", u), 32'(done[u]), 1 << w);
        check_eq("gnt_low_at_done", 32'(gnt[u]), 0);
        check_eq("gnt_hold", 32'(hold_ok), 1);
        check_eq("frame_len", 32'(tx_n[u] - base), 32'(len));
        for (int k = 0; k < len; k++)
            check_eq($sformatf("u%0d byte%0d", u, k), 32'(tx_buf[u][(base + k) & 1023]), 32'(b[k]));
        check_eq("status", 32'(status[u]), 32'(rx_buf[u][base & 1023]));
        check_eq("rdata", 32'(rdata[u]), 32'(rx_buf[u][(base + len - 1) & 1023]));
        $display("xfer u%0d client %0d %s addr=%h wdata=%h len=%0d status=%h rdata=%h",
                 u, w, cw[w] ? "wr" : "rd", b, cd[w], len, status[u], rdata[u]);
        done_cyc[u] = cyc;
        gap_chk[u]  = 1'b1;
        last_m[u]   = w;
        @(negedge clk);
        check_eq("done_pulse", 32'(done[u]), 0);
    endtask

    task automatic check_reset_state(input string tag);
        for (int u = 0; u < 2; u++) begin
            check_eq({tag, "_gnt"},    32'(gnt[u]), 0);
            check_eq({tag, "_done"},   32'(done[u]), 0);
            check_eq({tag, "_rdata"},  32'(rdata[u]), 0);
            check_eq({tag, "_status"}, 32'(status[u]), 0);
            check_eq({tag, "_m_d"},    32'(m_d[u]), 0);
            check_eq({tag, "_m_dv"},   32'(m_dv[u]), 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        bit no_done;
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        @(negedge clk);
        do_reset();
        check_reset_state("reset");

        // Rotation with all requests held: 0,1,2,3,0
        randomize_clients();
        for (int t = 0; t < N + 1; t++) do_xfer(0, 4'b1111, 1'b1, 1'b0);
        req[0] = '0;

        // Long write, client 0
        cw[0] = 1'b1; ca[0] = 14'h0003; cd[0] = 8'hE7;
        do_xfer(0, 4'b0001, 1'b0, 1'b0);

        // Long read, client 1, fixed slave replies
        cw[1] = 1'b0; ca[1] = 14'h0983; cd[1] = 8'h5A;
        plan(0, 8'hA5, 8'h3C, 8'h99);
        do_xfer(0, 4'b0010, 1'b0, 1'b0);
        check_eq("status_a5", 32'(status[0]), 32'h A5);
        check_eq("rdata_99", 32'(rdata[0]), 32'h99);

        // Short read on the short-frame instance
        cw[2] = 1'b0; ca[2] = 14'h0011; cd[2] = 8'hFF;
        plan(1, 8'h5A, 8'h77, 8'h00);
        do_xfer(1, 4'b0100, 1'b0, 1'b0);
        check_eq("short_rdata", 32'(rdata[1]), 32'h77);

        // Reset during the ADDR byte of a write, then retry
        cw[2] = 1'b1; ca[2] = 14'h0155; cd[2] = 8'h3C;
        drive(0);
        req[0] = 4'b0100;
        n = 0;
        while (gnt[0] == '0 && n < BUDGET) begin @(negedge clk); n++; end
        base = tx_n[0];
        req[0] = '0;
        while (tx_n[0] < base + 2 && n < BUDGET) begin @(negedge clk); n++; end
        check_eq("abort_reach_addr", 32'(n < BUDGET), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_m_dv", 32'(m_dv[0]), 0);
        check_eq("abort_gnt", 32'(gnt[0]), 0);
        check_eq("abort_done", 32'(done[0]), 0);
        check_eq("abort_status", 32'(status[0]), 0);
        check_eq("abort_m_d", 32'(m_d[0]), 0);
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin last_m[u] = N - 1; gap_chk[u] = 1'b0; end
        no_done = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done[0] != '0) no_done = 1'b0;
        end
        check_eq("abort_no_done", 32'(no_done), 1);
        do_xfer(0, 4'b0100, 1'b0, 1'b0);

        // Inputs changed and req dropped right after grant
        cw[1] = 1'b1; ca[1] = 14'h2A5C; cd[1] = 8'h81;
        do_xfer(0, 4'b0010, 1'b0, 1'b1);

        // Randomised traffic on both instances
        for (int t = 0; t < 25; t++) begin
            for (int u = 0; u < 2; u++) begin
                randomize_clients();
                do_xfer(u, 4'($urandom_range(1, 15)), 1'b0, 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_xfer_sched.md
# spi_xfer_sched

Transaction scheduler that shares one `spi_master` among `NR_REQUESTERS` on-chip clients. It round-robin arbitrates register-access requests, serialises each into the `spi_io` frame format (command byte, optional low-address byte, data byte) over the master's byte handshake, and returns the slave status byte and the read data. It sits between client logic and `spi_master`, in the same clock domain as the master's `clk`.

## Interface
- `NR_REQUESTERS`, 4: number of clients, 2..8.
- `SPI_DATA_WIDTH`, 8: byte width. Address width `AW = 2*SPI_DATA_WIDTH-2`.
- `SHORT_ADDR_EN`, 0: 1 allows the 2-byte frame when `addr[AW-1:SPI_DATA_WIDTH-2] == 0`.
- `GAP_CYCLES`, 4: idle clk cycles after `spi_cs_n` is seen high before the next grant, 1..255.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NR_REQUESTERS  per-client request level.
- `req_write`  in  NR_REQUESTERS  1 = write, 0 = read.
- `req_addr`  in  NR_REQUESTERS*AW  packed addresses, client i at `[i*AW +: AW]`.
- `req_wdata`  in  NR_REQUESTERS*SPI_DATA_WIDTH  packed write data.
- `gnt`  out  NR_REQUESTERS  one-hot grant, held for the whole transaction.
- `done`  out  NR_REQUESTERS  one-cycle completion pulse to the granted client.
- `rdata`  out  SPI_DATA_WIDTH  byte received during the data byte.
- `status`  out  SPI_DATA_WIDTH  byte received during the command byte.
- `m_spi_d`  out  SPI_DATA_WIDTH  byte to the master.
- `m_spi_dv`  out  1  byte valid to the master.
- `m_spi_dr`  in  1  master ready for a byte.
- `s_spi_d`  in  SPI_DATA_WIDTH  byte received by the master.
- `s_spi_dv`  in  1  received-byte strobe.
- `spi_cs_n`  in  1  master chip select, monitored only.

## Operation
- States: `WAIT_CS`, `GAP`, `IDLE`, `CMD`, `ADDR`, `DATA`, `DONE`. Each byte state has the sub-phases SEND, ACK and RX.
  - SEND: wait for `m_spi_dr=1`, then drive `m_spi_d` and set `m_spi_dv=1`.
  - ACK: wait for `m_spi_dr=0`, then clear `m_spi_dv`.
  - RX: wait for the `s_spi_dv` pulse and capture `s_spi_d`.
- Reset enters `WAIT_CS`. `WAIT_CS` waits for `spi_cs_n=1`, then `GAP` counts `GAP_CYCLES`, then `IDLE`.
- `IDLE` with any `req` bit set:
  - Grant the first set bit searching upward from `last+1`, wrapping at `NR_REQUESTERS-1`.
  - The `last` pointer resets to `NR_REQUESTERS-1`, so client 0 wins first.
  - Latch that client's write, addr and wdata; later changes on those inputs are ignored.
- Frame is long if `SHORT_ADDR_EN=0` or the high address bits are nonzero:
  - CMD byte = `{write, 1, addr[AW-1:SPI_DATA_WIDTH]}`.
  - ADDR byte = `addr[SPI_DATA_WIDTH-1:0]`.
  - DATA byte = wdata for a write, 0x00 for a read.
- Short frame: CMD byte = `{write, 0, addr[SPI_DATA_WIDTH-3:0]}`, `ADDR` is skipped, then DATA.
- Received bytes:
  - Byte received during CMD goes to `status`.
  - Byte received during ADDR is discarded.
  - Byte received during DATA goes to `rdata`.
- `DONE`: pulse the `done` bit, drop `gnt`, update `last`, go to `WAIT_CS`.
- A `req` deasserted after grant does not abort the transaction; `done` still pulses.

## Timing
- Reset values: `gnt=0`, `done=0`, `rdata=0`, `status=0`, `m_spi_d=0`, `m_spi_dv=0`, `last=NR_REQUESTERS-1`, gap counter 0.
- `gnt` rises 1 cycle after `req` is sampled in `IDLE`.
- CMD SEND is entered in the same cycle `gnt` rises.
- `m_spi_dv` rises 1 cycle after `m_spi_dr` is sampled high, and falls 1 cycle after `m_spi_dr` is sampled low.
- `m_spi_d` is stable while `m_spi_dv=1`.
- `rdata` updates 1 cycle after the DATA `s_spi_dv`.
- `done` pulses 1 cycle after the DATA `s_spi_dv`. `gnt` is low in that same cycle.
- `rdata` and `status` hold until the next capture.
- `s_spi_dv` is ignored outside RX sub-phases.
- Next grant comes no earlier than `GAP_CYCLES+1` cycles after `spi_cs_n` is seen high.
- `rst` mid-transaction:
  - All outputs return to reset values next cycle; `m_spi_dv` drops immediately and the partial frame is abandoned.
  - The master's in-flight byte completes on its own; `WAIT_CS` covers it.
- Simultaneous `req` from all clients: strict rotation, no client waits more than `NR_REQUESTERS-1` transactions.

## Test plan
- Long write, client 0, addr 0x0003, wdata 0xE7 → master receives bytes 0xC0, 0x03, 0xE7; `done[0]` pulses once; `gnt` is one-hot throughout.
- Long read, client 1, addr 0x0983, slave status 0xA5, data 0x99 → bytes sent 0x49, 0x83, 0x00; `status=0xA5`, `rdata=0x99`.
- `SHORT_ADDR_EN=1`, read addr 0x0011 → bytes sent 0x11, 0x00 (2 bytes only); `rdata` is the second received byte.
- Arbitration: `req=4'b1111` held after reset → grant order 0,1,2,3,0; each pair of grants separated by at least `GAP_CYCLES` after `spi_cs_n` rises.
- Reset asserted during ADDR of a write → next cycle `m_spi_dv=0`, `gnt=0`, no `done`; a retried transaction then completes with correct bytes.
- Requester changes `req_addr` and drops `req` right after `gnt` → latched values still sent; `done` still pulses.
